id_decode_ctrl: RTL and testbench
=================================

Name: id_decode_ctrl

Overview:
- Instruction-decode stage core for the 5-stage DLX-style pipeline.
- Holds the IF/ID pipeline register (instruction and PC+4) with stall and squash control.
- Decodes the latched instruction into datapath control signals.
- Computes branch/jump targets with internal 32-bit adders and resolves BEQZ/BNEZ using a zero comparator on the forwarded rs1 operand.

Parameters:
- NOP_WORD, 32'h00000015, instruction word loaded on reset or squash (R-type NOP).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the pipeline register
- squash  in  1  flush the pipeline register to NOP
- inst_in  in  32  fetched instruction
- pc4_in  in  32  PC+4 of the fetched instruction
- rs1_val  in  32  forwarded rs1 operand, used for the zero test
- instruction  out  32  latched instruction
- pc4  out  32  latched PC+4
- imm32  out  32  extended immediate
- branch_target  out  32  pc4 + {imm32[31:2],2'b00}
- jump_target  out  32  pc4 + sign-extended instruction[25:0]
- rs1, rs2, destreg  out  5 each  register specifiers
- regdst, alusrc, mem2reg, regwrite, memwrite, jump, jal, jar, loadext  out  1 each  control signals
- branch  out  1  branch taken
- aluctrl  out  4  ALU operation
- dsize  out  2  memory access size: 0 byte, 1 half, 2 word

Behaviour:
- Pipeline register update, evaluated at each posedge, in this priority order:
  - reset or squash: instruction=NOP_WORD, pc4=0.
  - stall: hold both values.
  - otherwise: load inst_in and pc4_in.
  - Squash overrides stall.
- Everything downstream of the register is combinational; all outputs are valid in the same cycle the register updates.
- Field layout:
  - op = [31:26]
  - rs1 = [25:21]
  - I-type destination = [20:16]
  - R-type rs2 = [20:16], rd = [15:11], funct = [5:0]
- Immediate: imm32 = {16{imm[15]&extop}, imm[15:0]}.
  - extop=0 for ADDUI (09), SUBUI (0B), ANDI (0C), ORI (0D), XORI (0E).
  - extop=1 for all other opcodes.
- aluctrl encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA
  - 8 SEQ, 9 SNE, A SLT, B SGT, C SLE, D SGE
  - E LHI, F NOP/pass
- R-type (op=00), funct to aluctrl:
  - 20/21 -> 0, 22/23 -> 1, 24 -> 2, 25 -> 3, 26 -> 4
  - 04 -> 5, 06 -> 6, 07 -> 7
  - 28..2D -> 8..D
  - R-type control: regdst=1, regwrite=1.
  - funct 15 (NOP) and any unlisted funct: all write/enable controls 0, aluctrl=F.
- I-type ALU opcodes: alusrc=1, regwrite=1, regdst=0.
  - 08..0E map the same way as their R-type counterparts.
  - 0F LHI -> E; 14 -> 5, 16 -> 6, 17 -> 7; 18..1D -> 8..D.
- Loads (alusrc=1, mem2reg=1, regwrite=1, aluctrl=0):
  - 20 LB: dsize 0, loadext 1
  - 21 LH: dsize 1, loadext 1
  - 23 LW: dsize 2
  - 24 LBU: dsize 0, loadext 0
  - 25 LHU: dsize 1, loadext 0
- Stores (alusrc=1, memwrite=1, aluctrl=0): 28 SB dsize 0, 29 SH dsize 1, 2B SW dsize 2.
- Branches: 04 BEQZ, 05 BNEZ.
  - Internal branch_op=1.
  - branch = branch_op & (instruction[26] ? rs1_val!=0 : rs1_val==0).
- Jumps (all assert jump=1):
  - 02 J.
  - 03 JAL: jal=1, regwrite=1, destreg=31.
  - 12 JR: jar=1.
  - 13 JALR: jar=1, jal=1, regwrite=1, destreg=31.
- destreg = regdst ? [15:11] : [20:16], except JAL/JALR, which force 31.
- Unused controls are 0; undefined opcodes decode exactly as NOP.
- Adders wrap modulo 2^32; carry-out is discarded.
- Zero comparator is a full 32-bit equality against 0.

Test Plan:
- Assert reset, then release -> instruction=00000015, pc4=0, regwrite=memwrite=branch=jump=0, aluctrl=F.
- Load ADD r3,r1,r2 (00221820) -> regdst=1, regwrite=1, aluctrl=0, destreg=3, rs1=1, rs2=2.
- Load BEQZ r1,-4 (1020FFFC) with pc4_in=100:
  - rs1_val=0 -> branch=1, branch_target=FC.
  - rs1_val=5 -> branch=0.
- Load BNEZ (1420FFFC) with rs1_val=5 -> branch=1; with rs1_val=0 -> branch=0.
- Load LBU r4,8(r2) (90440008) -> mem2reg=1, dsize=0, loadext=0, imm32=8. Load ORI with imm 8000 -> imm32=00008000 (zero-extended).
- Stall held with a new inst_in -> instruction unchanged. Stall and squash asserted together -> instruction=00000015. JAL -> jump=1, jal=1, destreg=31.

Source files
------------

// File: rtl/id_decode_ctrl.sv
// DLX instruction-decode stage: IF/ID pipeline register with stall/squash, control
// decode, branch/jump target adders and the BEQZ/BNEZ zero test on the forwarded rs1.
module id_decode_ctrl #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0015
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        squash,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc4_in,
    input  logic [31:0] rs1_val,
    output logic [31:0] instruction,
    output logic [31:0] pc4,
    output logic [31:0] imm32,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  destreg,
    output logic        regdst,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memwrite,
    output logic        jump,
    output logic        jal,
    output logic        jar,
    output logic        loadext,
    output logic        branch,
    output logic [3:0]  aluctrl,
    output logic [1:0]  dsize
);

    localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4, ALU_SLL = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_SEQ = 4'h8, ALU_SNE = 4'h9, ALU_SLT = 4'hA, ALU_SGT = 4'hB;
    localparam logic [3:0] ALU_SLE = 4'hC, ALU_SGE = 4'hD, ALU_LHI = 4'hE, ALU_NOP = 4'hF;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    // Squash shares the reset path so it wins over stall.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (reset || squash) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'h0;
        end else if (!stall) begin
            instr_d = inst_in;
            pc4_d   = pc4_in;
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc4_q   <= pc4_d;
    end

    logic [5:0] op;
    logic [5:0] funct;
    logic       extop;
    logic       branch_op;

    assign op    = instr_q[31:26];
    assign funct = instr_q[5:0];

    always_comb begin
        regdst    = 1'b0;
        alusrc    = 1'b0;
        mem2reg   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        jump      = 1'b0;
        jal       = 1'b0;
        jar       = 1'b0;
        loadext   = 1'b0;
        branch_op = 1'b0;
        extop     = 1'b1;
        aluctrl   = ALU_NOP;
        dsize     = 2'd0;
        case (op)
            6'h00: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                case (funct)
                    6'h20, 6'h21: aluctrl = ALU_ADD;
                    6'h22, 6'h23: aluctrl = ALU_SUB;
                    6'h24:        aluctrl = ALU_AND;
                    6'h25:        aluctrl = ALU_OR;
                    6'h26:        aluctrl = ALU_XOR;
                    6'h04:        aluctrl = ALU_SLL;
                    6'h06:        aluctrl = ALU_SRL;
                    6'h07:        aluctrl = ALU_SRA;
                    6'h28:        aluctrl = ALU_SEQ;
                    6'h29:        aluctrl = ALU_SNE;
                    6'h2A:        aluctrl = ALU_SLT;
                    6'h2B:        aluctrl = ALU_SGT;
                    6'h2C:        aluctrl = ALU_SLE;
                    6'h2D:        aluctrl = ALU_SGE;
                    default: begin
                        // NOP and unknown functs write nothing
                        regdst   = 1'b0;
                        regwrite = 1'b0;
                        aluctrl  = ALU_NOP;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h14, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
                case (op)
                    6'h08, 6'h09: aluctrl = ALU_ADD;
                    6'h0A, 6'h0B: aluctrl = ALU_SUB;
                    6'h0C:        aluctrl = ALU_AND;
                    6'h0D:        aluctrl = ALU_OR;
                    6'h0E:        aluctrl = ALU_XOR;
                    6'h0F:        aluctrl = ALU_LHI;
                    6'h14:        aluctrl = ALU_SLL;
                    6'h16:        aluctrl = ALU_SRL;
                    6'h17:        aluctrl = ALU_SRA;
                    6'h18:        aluctrl = ALU_SEQ;
                    6'h19:        aluctrl = ALU_SNE;
                    6'h1A:        aluctrl = ALU_SLT;
                    6'h1B:        aluctrl = ALU_SGT;
                    6'h1C:        aluctrl = ALU_SLE;
                    default:      aluctrl = ALU_SGE;
                endcase
                if (op == 6'h09 || op == 6'h0B || op == 6'h0C || op == 6'h0D || op == 6'h0E)
                    extop = 1'b0;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                alusrc   = 1'b1;
                mem2reg  = 1'b1;
                regwrite = 1'b1;
                aluctrl  = ALU_ADD;
                loadext  = (op == 6'h20) || (op == 6'h21);
                dsize    = (op == 6'h23) ? 2'd2 : ((op == 6'h21 || op == 6'h25) ? 2'd1 : 2'd0);
            end
            6'h28, 6'h29, 6'h2B: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
                aluctrl  = ALU_ADD;
                dsize    = (op == 6'h2B) ? 2'd2 : ((op == 6'h29) ? 2'd1 : 2'd0);
            end
            6'h04, 6'h05: branch_op = 1'b1;
            6'h02: jump = 1'b1;
            6'h03: begin
                jump     = 1'b1;
                jal      = 1'b1;
                regwrite = 1'b1;
            end
            6'h12: begin
                jump = 1'b1;
                jar  = 1'b1;
            end
            6'h13: begin
                jump     = 1'b1;
                jar      = 1'b1;
                jal      = 1'b1;
                regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign instruction   = instr_q;
    assign pc4           = pc4_q;
    assign rs1           = instr_q[25:21];
    assign rs2           = instr_q[20:16];
    assign destreg       = jal ? 5'd31 : (regdst ? instr_q[15:11] : instr_q[20:16]);
    assign imm32         = {{16{instr_q[15] & extop}}, instr_q[15:0]};
    assign branch_target = pc4_q + {imm32[31:2], 2'b00};
    assign jump_target   = pc4_q + {{6{instr_q[25]}}, instr_q[25:0]};
    // instruction[26] separates BNEZ (05) from BEQZ (04)
    assign branch        = branch_op & (instr_q[26] ? (rs1_val != 32'h0) : (rs1_val == 32'h0));

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Self-checking bench for id_decode_ctrl: directed test-plan steps, then randomized
// instructions/stall/squash/reset compared against a table-driven reference model.
module tb_id_decode_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0015;

    logic        clk = 1'b0;
    logic        reset, stall, squash;
    logic [31:0] inst_in, pc4_in, rs1_val;
    logic [31:0] instruction, pc4, imm32, branch_target, jump_target;
    logic [4:0]  rs1, rs2, destreg;
    logic        regdst, alusrc, mem2reg, regwrite, memwrite, jump, jal, jar, loadext, branch;
    logic [3:0]  aluctrl;
    logic [1:0]  dsize;

    always #5 clk = ~clk;

    id_decode_ctrl #(.NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .squash(squash),
        .inst_in(inst_in), .pc4_in(pc4_in), .rs1_val(rs1_val),
        .instruction(instruction), .pc4(pc4), .imm32(imm32),
        .branch_target(branch_target), .jump_target(jump_target),
        .rs1(rs1), .rs2(rs2), .destreg(destreg),
        .regdst(regdst), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
        .memwrite(memwrite), .jump(jump), .jal(jal), .jar(jar), .loadext(loadext),
        .branch(branch), .aluctrl(aluctrl), .dsize(dsize)
    );

    typedef struct packed {
        logic [31:0] imm32, bt, jt;
        logic [4:0]  rs1, rs2, dest;
        logic        regdst, alusrc, mem2reg, regwrite, memwrite, jump, jal, jar, loadext, branch;
        logic [3:0]  alu;
        logic [1:0]  dsize;
    } exp_t;

    // Opcode classes for the reference tables
    localparam int C_NOP = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BR = 5, C_J = 6;

    int cls[64];
    int r_alu[64];
    int i_alu[64];
    int msize[64];
    bit zext[64];
    int valid_ops[$];
    int valid_functs[$];

    logic [31:0] m_inst, m_pc4;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p4, input logic [31:0] rv);
        exp_t e;
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        e = '0;
        e.alu   = 4'hF;
        e.rs1   = ins[25:21];
        e.rs2   = ins[20:16];
        e.imm32 = zext[op] ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        e.bt    = p4 + (e.imm32 & 32'hFFFF_FFFC);
        e.jt    = p4 + {{6{ins[25]}}, ins[25:0]};
        case (cls[op])
            C_R: if (r_alu[fn] >= 0) begin
                e.regdst = 1; e.regwrite = 1; e.alu = 4'(r_alu[fn]);
            end
            C_I: begin
                e.alusrc = 1; e.regwrite = 1; e.alu = 4'(i_alu[op]);
            end
            C_LD: begin
                e.alusrc = 1; e.mem2reg = 1; e.regwrite = 1; e.alu = 4'h0;
                e.dsize = 2'(msize[op]);
                e.loadext = (op == 'h20 || op == 'h21);
            end
            C_ST: begin
                e.alusrc = 1; e.memwrite = 1; e.alu = 4'h0; e.dsize = 2'(msize[op]);
            end
            C_BR: e.branch = (op == 'h05) ? (rv != 0) : (rv == 0);
            C_J: begin
                e.jump = 1;
                e.jal = (op == 'h03 || op == 'h13);
                e.jar = (op == 'h12 || op == 'h13);
                e.regwrite = e.jal;
            end
            default: ;
        endcase
        e.dest = e.jal ? 5'd31 : (e.regdst ? ins[15:11] : ins[20:16]);
        return e;
    endfunction

    task automatic check_all();
        exp_t e;
        e = model(m_inst, m_pc4, rs1_val);
        chk("instruction", instruction, m_inst);
        chk("pc4", pc4, m_pc4);
        chk("imm32", imm32, e.imm32);
        chk("branch_target", branch_target, e.bt);
        chk("jump_target", jump_target, e.jt);
        chk("rs1", 32'(rs1), 32'(e.rs1));
        chk("rs2", 32'(rs2), 32'(e.rs2));
        chk("destreg", 32'(destreg), 32'(e.dest));
        chk("regdst", 32'(regdst), 32'(e.regdst));
        chk("alusrc", 32'(alusrc), 32'(e.alusrc));
        chk("mem2reg", 32'(mem2reg), 32'(e.mem2reg));
        chk("regwrite", 32'(regwrite), 32'(e.regwrite));
        chk("memwrite", 32'(memwrite), 32'(e.memwrite));
        chk("jump", 32'(jump), 32'(e.jump));
        chk("jal", 32'(jal), 32'(e.jal));
        chk("jar", 32'(jar), 32'(e.jar));
        chk("loadext", 32'(loadext), 32'(e.loadext));
        chk("branch", 32'(branch), 32'(e.branch));
        chk("aluctrl", 32'(aluctrl), 32'(e.alu));
        chk("dsize", 32'(dsize), 32'(e.dsize));
    endtask

    task automatic tick(input logic r, input logic st, input logic sq,
                        input logic [31:0] ins, input logic [31:0] p4);
        reset = r; stall = st; squash = sq; inst_in = ins; pc4_in = p4;
        @(posedge clk);
        if (r || sq) begin
            m_inst = NOP;
            m_pc4  = 32'h0;
        end else if (!st) begin
            m_inst = ins;
            m_pc4  = p4;
        end
        #1;
    endtask

    task automatic init_tables();
        for (int i = 0; i < 64; i++) begin
            cls[i] = C_NOP; r_alu[i] = -1; i_alu[i] = 15; msize[i] = 0; zext[i] = 0;
        end
        cls[0] = C_R;
        r_alu['h20] = 0; r_alu['h21] = 0; r_alu['h22] = 1; r_alu['h23] = 1;
        r_alu['h24] = 2; r_alu['h25] = 3; r_alu['h26] = 4;
        r_alu['h04] = 5; r_alu['h06] = 6; r_alu['h07] = 7;
        for (int k = 0; k < 6; k++) r_alu['h28 + k] = 8 + k;
        for (int k = 0; k < 7; k++) begin
            i_alu['h08 + k] = r_alu['h20 + k]; cls['h08 + k] = C_I;
        end
        i_alu['h0F] = 14; i_alu['h14] = 5; i_alu['h16] = 6; i_alu['h17] = 7;
        cls['h0F] = C_I; cls['h14] = C_I; cls['h16] = C_I; cls['h17] = C_I;
        for (int k = 0; k < 6; k++) begin
            i_alu['h18 + k] = 8 + k; cls['h18 + k] = C_I;
        end
        zext['h09] = 1; zext['h0B] = 1; zext['h0C] = 1; zext['h0D] = 1; zext['h0E] = 1;
        cls['h20] = C_LD; msize['h20] = 0; cls['h21] = C_LD; msize['h21] = 1;
        cls['h23] = C_LD; msize['h23] = 2; cls['h24] = C_LD; msize['h24] = 0;
        cls['h25] = C_LD; msize['h25] = 1;
        cls['h28] = C_ST; msize['h28] = 0; cls['h29] = C_ST; msize['h29] = 1;
        cls['h2B] = C_ST; msize['h2B] = 2;
        cls['h04] = C_BR; cls['h05] = C_BR;
        cls['h02] = C_J; cls['h03] = C_J; cls['h12] = C_J; cls['h13] = C_J;
        for (int i = 0; i < 64; i++) begin
            if (cls[i] != C_NOP) valid_ops.push_back(i);
            if (r_alu[i] >= 0) valid_functs.push_back(i);
        end
        valid_functs.push_back('h15);
    endtask

    initial begin
        logic [31:0] ins;
        init_tables();
        m_inst = NOP; m_pc4 = 32'h0;
        reset = 1; stall = 0; squash = 0; inst_in = 32'h0; pc4_in = 32'h0; rs1_val = 32'h0;

        // Reset state
        tick(1, 0, 0, 32'h00221820, 32'h44);
        tick(1, 0, 0, 32'h00221820, 32'h44);
        chk("rst_instruction", instruction, 32'h0000_0015);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_regwrite", 32'(regwrite), 32'h0);
        chk("rst_memwrite", 32'(memwrite), 32'h0);
        chk("rst_branch", 32'(branch), 32'h0);
        chk("rst_jump", 32'(jump), 32'h0);
        chk("rst_aluctrl", 32'(aluctrl), 32'hF);
        check_all();

        // ADD r3,r1,r2
        tick(0, 0, 0, 32'h00221820, 32'h0000_0008);
        chk("add_regdst", 32'(regdst), 32'h1);
        chk("add_regwrite", 32'(regwrite), 32'h1);
        chk("add_aluctrl", 32'(aluctrl), 32'h0);
        chk("add_destreg", 32'(destreg), 32'd3);
        chk("add_rs1", 32'(rs1), 32'd1);
        chk("add_rs2", 32'(rs2), 32'd2);
        check_all();

        // BEQZ r1,-4 at pc4=0x100
        rs1_val = 32'h0;
        tick(0, 0, 0, 32'h1020FFFC, 32'h100);
        chk("beqz_taken", 32'(branch), 32'h1);
        chk("beqz_target", branch_target, 32'h0000_00FC);
        check_all();
        rs1_val = 32'h5; #1;
        chk("beqz_not_taken", 32'(branch), 32'h0);
        check_all();

        // BNEZ
        rs1_val = 32'h5;
        tick(0, 0, 0, 32'h1420FFFC, 32'h100);
        chk("bnez_taken", 32'(branch), 32'h1);
        rs1_val = 32'h0; #1;
        chk("bnez_not_taken", 32'(branch), 32'h0);
        rs1_val = 32'h8000_0000; #1;
        chk("bnez_msb_only", 32'(branch), 32'h1);
        check_all();

        // LBU r4,8(r2), then ORI with a zero-extended 0x8000
        tick(0, 0, 0, 32'h90440008, 32'h200);
        chk("lbu_mem2reg", 32'(mem2reg), 32'h1);
        chk("lbu_dsize", 32'(dsize), 32'h0);
        chk("lbu_loadext", 32'(loadext), 32'h0);
        chk("lbu_imm32", imm32, 32'h8);
        check_all();
        tick(0, 0, 0, 32'h34218000, 32'h204);
        chk("ori_imm32", imm32, 32'h0000_8000);
        check_all();

        // Stall holds; squash beats stall; JAL
        tick(0, 1, 0, 32'h00221820, 32'h208);
        chk("stall_hold", instruction, 32'h34218000);
        chk("stall_pc4", pc4, 32'h204);
        tick(0, 1, 1, 32'h00221820, 32'h208);
        chk("squash_over_stall", instruction, 32'h0000_0015);
        chk("squash_pc4", pc4, 32'h0);
        tick(0, 0, 0, 32'h0FFFFFFC, 32'h1000);
        chk("jal_jump", 32'(jump), 32'h1);
        chk("jal_jal", 32'(jal), 32'h1);
        chk("jal_destreg", 32'(destreg), 32'd31);
        chk("jal_target", jump_target, 32'h0000_0FFC);
        check_all();

        // Randomized instructions with random stall/squash/reset
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0)
                ins[31:26] = 6'(valid_ops[$urandom_range(0, valid_ops.size() - 1)]);
            if (ins[31:26] == 6'h0 && $urandom_range(0, 3) != 0)
                ins[5:0] = 6'(valid_functs[$urandom_range(0, valid_functs.size() - 1)]);
            rs1_val = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            tick($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 8, ins, $urandom);
            check_all();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
